game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Consumes the divided 1 Hz square wave from the clock divider and runs the whack-a-mole round countdown in the system clk domain.
- Presents remaining time as two BCD digits to the display scan stage.
- Flags time-up and low-time to the game controller.
- The 1 Hz signal is treated as data: edge-detected, never used as a clock.

Parameters:
- GAME_SECONDS, 60, round length in seconds; legal range 1..99; elaboration error outside the range.
- WARN_SECONDS, 10, low_time asserts when remaining seconds <= this value; legal range 0..GAME_SECONDS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_1hz  in  1  1 Hz square wave from the divider, same clk domain, registered at its source
- start  in  1  single-cycle pulse: (re)start the round
- pause_tgl  in  1  single-cycle pulse: toggle between RUN and PAUSE
- sec_tens  out  4  BCD tens digit of remaining seconds
- sec_ones  out  4  BCD ones digit of remaining seconds
- running  out  1  high in RUN
- paused  out  1  high in PAUSE
- time_up  out  1  high in DONE
- done_pulse  out  1  one-cycle pulse on the RUN->DONE transition
- low_time  out  1  high in RUN/PAUSE when remaining <= WARN_SECONDS

Behaviour:
- Reset values:
  - state IDLE.
  - sec_tens/sec_ones = BCD of GAME_SECONDS.
  - running, paused, time_up, done_pulse, low_time = 0.
  - Edge-detect history flop = 0.
- Tick generation:
  - tick = clk_1hz & ~clk_1hz_q, where clk_1hz_q is the previous-cycle sample.
  - Exactly one tick per rising edge.
  - A clk_1hz already high out of reset produces a tick in the first cycle after reset; it is ignored because state is IDLE.
- States: IDLE, RUN, PAUSE, DONE. Encoding from the shared package.
- IDLE:
  - start -> RUN, digits reloaded to GAME_SECONDS.
  - tick and pause_tgl ignored.
- RUN:
  - start -> RUN with reload. start wins over tick and pause_tgl in the same cycle.
  - Otherwise pause_tgl -> PAUSE. pause_tgl wins over a same-cycle tick; no decrement.
  - Otherwise, on tick, decrement BCD: ones==0 -> ones=9 and tens-=1; else ones-=1.
  - If the pre-decrement value is 01, the next state is DONE and digits become 00.
- PAUSE:
  - Digits hold; ticks discarded, not queued.
  - pause_tgl -> RUN.
  - start -> RUN with reload; start wins.
- DONE:
  - Digits hold 00; ticks and pause_tgl ignored.
  - start -> RUN with reload.
- Latency:
  - Digit update, state change and all status outputs are registered, 1 clk after the qualifying input cycle.
  - done_pulse is high for exactly the one cycle in which time_up first reads 1.
- First decrement after start occurs at the next clk_1hz rising edge, 0 to 1 s later, depending on divider phase. This is accepted; the divider is not resynchronised.
- Digits never leave 0..9, and never wrap below 00.
- Outputs decode directly from registered state: running, paused, time_up, low_time.
- low_time compares the binary value tens*10+ones against WARN_SECONDS, combinationally from registered digits and state, then registered.
- Asynchronous reset at any time returns all state to reset values, with no done_pulse.

Decomposition:
- Shared package game_pkg:
  - state typedef/localparams (IDLE, RUN, PAUSE, DONE).
  - BCD_W=4.
  - function bcd_of(int) for parameter-to-BCD reload values.
- One sub-module, rise_edge_det (clk, rst_n, d, pulse), reused later for button pulses.
- BCD decrement stays inline.

Test Plan:
- Reset with clk_1hz toggling -> digits 6/0, all flags 0, digits unchanged after 3 rising edges of clk_1hz.
- GAME_SECONDS=3, WARN_SECONDS=2, pulse start, drive 3 rising edges of clk_1hz:
  - digits 3 -> 2 -> 1 -> 0, each 1 clk after its edge.
  - low_time rises at 2.
  - done_pulse is exactly 1 cycle.
  - time_up held; a 4th edge leaves 00.
- GAME_SECONDS=12 from 10 on a tick -> 09; from 20 -> 19; no out-of-range BCD.
- RUN at 05:
  - pause_tgl coincident with tick -> PAUSE at 05.
  - 2 edges -> still 05.
  - pause_tgl -> RUN; next edge -> 04.
- start coincident with tick and pause_tgl in RUN at 07 -> RUN reloaded to GAME_SECONDS; no decrement, not paused.
- Assert rst_n low mid-RUN at 04 -> immediate IDLE, digits GAME_SECONDS, no done_pulse.
- In DONE, start -> RUN with digits GAME_SECONDS, time_up cleared.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the whack-a-mole game blocks.
//   state_t : round state of the countdown timer (IDLE, RUN, PAUSE, DONE)
//   BCD_W   : width of one BCD digit
//   bcd_of  : converts a 0..99 integer into {tens, ones} BCD, used to build
//             reload constants from parameters
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Split a two-digit decimal number into packed {tens, ones} BCD digits.
    function automatic logic [2*BCD_W-1:0] bcd_of(input int value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(value / 10);
        ones = BCD_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// ---------------------------------------------------------------------------
// rise_edge_det
// Turns a level signal that already lives in the clk domain into a one-cycle
// pulse on each 0->1 transition. The history flop resets to 0, so a level
// that is already high out of reset yields a pulse in the first cycle.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : level input (must be synchronous to clk)
//   pulse : high for one cycle when d is 1 and was 0 in the previous cycle
// ---------------------------------------------------------------------------
module rise_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic d_d;
    logic d_q;

    always_comb begin
        d_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign pulse = d & ~d_q;

endmodule

// File: rtl/game_countdown_timer.sv
// ---------------------------------------------------------------------------
// game_countdown_timer
// Round countdown for the whack-a-mole game. The 1 Hz square wave from the
// divider is sampled as data and edge-detected; each rising edge is one
// second of play. Remaining time is kept as two BCD digits for the display.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   clk_1hz     : 1 Hz square wave, registered in the clk domain
//   start       : one-cycle pulse, (re)starts the round from GAME_SECONDS
//   pause_tgl   : one-cycle pulse, toggles RUN <-> PAUSE
//   sec_tens/
//   sec_ones    : BCD digits of remaining seconds
//   running     : round is counting
//   paused      : round is frozen
//   time_up     : round has ended
//   done_pulse  : one cycle, on the cycle time_up first reads 1
//   low_time    : remaining <= WARN_SECONDS while RUN or PAUSE
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module game_countdown_timer
    import game_pkg::*;
#(
    parameter int GAME_SECONDS = 60,
    parameter int WARN_SECONDS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_1hz,
    input  logic             start,
    input  logic             pause_tgl,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             paused,
    output logic             time_up,
    output logic             done_pulse,
    output logic             low_time
);

    if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_game_seconds
        $error("game_countdown_timer: GAME_SECONDS must be within 1..99");
    end

    if (WARN_SECONDS < 0 || WARN_SECONDS > GAME_SECONDS) begin : g_bad_warn_seconds
        $error("game_countdown_timer: WARN_SECONDS must be within 0..GAME_SECONDS");
    end

    localparam logic [2*BCD_W-1:0] RELOAD      = bcd_of(GAME_SECONDS);
    localparam logic [BCD_W-1:0]   RELOAD_TENS = RELOAD[2*BCD_W-1:BCD_W];
    localparam logic [BCD_W-1:0]   RELOAD_ONES = RELOAD[BCD_W-1:0];
    localparam logic [6:0]         WARN_LIMIT  = 7'(WARN_SECONDS);

    logic tick;

    rise_edge_det u_tick_det (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk_1hz),
        .pulse (tick)
    );

    state_t           state_d, state_q;
    logic [BCD_W-1:0] tens_d, tens_q;
    logic [BCD_W-1:0] ones_d, ones_q;
    logic             running_d, running_q;
    logic             paused_d, paused_q;
    logic             time_up_d, time_up_q;
    logic             done_pulse_d, done_pulse_q;
    logic             low_time_d, low_time_q;
    logic [6:0]       remaining_d;

    // Next-state logic. Priority within RUN is start, then pause_tgl, then
    // tick, so a tick that coincides with a pause is dropped, not deferred.
    // The status flags are decoded from the next state so that they change
    // in the same cycle as the digits they describe.
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    tens_d  = RELOAD_TENS;
                    ones_d  = RELOAD_ONES;
                end
            end
            ST_RUN: begin
                if (start) begin
                    tens_d = RELOAD_TENS;
                    ones_d = RELOAD_ONES;
                end else if (pause_tgl) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    // Reaching 00 ends the round; the <= 1 guard keeps the
                    // digits from ever wrapping below 00.
                    if (tens_q == '0 && ones_q <= 4'd1) begin
                        state_d = ST_DONE;
                        tens_d  = '0;
                        ones_d  = '0;
                    end else if (ones_q == '0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (start) begin
                    state_d = ST_RUN;
                    tens_d  = RELOAD_TENS;
                    ones_d  = RELOAD_ONES;
                end else if (pause_tgl) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    tens_d  = RELOAD_TENS;
                    ones_d  = RELOAD_ONES;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        remaining_d  = 7'(tens_d) * 7'd10 + 7'(ones_d);
        running_d    = (state_d == ST_RUN);
        paused_d     = (state_d == ST_PAUSE);
        time_up_d    = (state_d == ST_DONE);
        done_pulse_d = (state_q == ST_RUN) && (state_d == ST_DONE);
        low_time_d   = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                       (remaining_d <= WARN_LIMIT);
    end

    // State, digits and status flags; reset restores a full round in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tens_q       <= RELOAD_TENS;
            ones_q       <= RELOAD_ONES;
            running_q    <= 1'b0;
            paused_q     <= 1'b0;
            time_up_q    <= 1'b0;
            done_pulse_q <= 1'b0;
            low_time_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            running_q    <= running_d;
            paused_q     <= paused_d;
            time_up_q    <= time_up_d;
            done_pulse_q <= done_pulse_d;
            low_time_q   <= low_time_d;
        end
    end

    assign sec_tens   = tens_q;
    assign sec_ones   = ones_q;
    assign running    = running_q;
    assign paused     = paused_q;
    assign time_up    = time_up_q;
    assign done_pulse = done_pulse_q;
    assign low_time   = low_time_q;

endmodule

// File: tb/tb_game_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_game_countdown_timer
// Three timer instances share one stimulus stream: index 0 uses the default
// 60/10 round, index 1 a 3/2 round, index 2 a 12/10 round. Each check names
// the instance whose outputs it compares.
// ---------------------------------------------------------------------------
module tb_game_countdown_timer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_1hz;
    logic       start;
    logic       pause_tgl;

    logic [3:0] sec_tens   [3];
    logic [3:0] sec_ones   [3];
    logic       running    [3];
    logic       paused     [3];
    logic       time_up    [3];
    logic       done_pulse [3];
    logic       low_time   [3];

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        string      name;
        int         sel;
        logic       hz;
        logic       st;
        logic       pt;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       run;
        logic       pau;
        logic       tu;
        logic       dp;
        logic       low;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    game_countdown_timer #(.GAME_SECONDS(60), .WARN_SECONDS(10)) dut60 (
        .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .start(start), .pause_tgl(pause_tgl),
        .sec_tens(sec_tens[0]), .sec_ones(sec_ones[0]), .running(running[0]), .paused(paused[0]),
        .time_up(time_up[0]), .done_pulse(done_pulse[0]), .low_time(low_time[0])
    );

    game_countdown_timer #(.GAME_SECONDS(3), .WARN_SECONDS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .start(start), .pause_tgl(pause_tgl),
        .sec_tens(sec_tens[1]), .sec_ones(sec_ones[1]), .running(running[1]), .paused(paused[1]),
        .time_up(time_up[1]), .done_pulse(done_pulse[1]), .low_time(low_time[1])
    );

    game_countdown_timer #(.GAME_SECONDS(12), .WARN_SECONDS(10)) dut12 (
        .clk(clk), .rst_n(rst_n), .clk_1hz(clk_1hz), .start(start), .pause_tgl(pause_tgl),
        .sec_tens(sec_tens[2]), .sec_ones(sec_ones[2]), .running(running[2]), .paused(paused[2]),
        .time_up(time_up[2]), .done_pulse(done_pulse[2]), .low_time(low_time[2])
    );

    function automatic void addVec(input string name, input int sel,
                                   input logic hz, input logic st, input logic pt,
                                   input logic [3:0] tens, input logic [3:0] ones,
                                   input logic run, input logic pau, input logic tu,
                                   input logic dp, input logic low);
        vec_t v;
        v.name = name; v.sel = sel; v.hz = hz; v.st = st; v.pt = pt;
        v.tens = tens; v.ones = ones; v.run = run; v.pau = pau;
        v.tu = tu; v.dp = dp; v.low = low;
        vecs.push_back(v);
    endfunction

    function automatic logic [12:0] pk(input logic [3:0] t, input logic [3:0] o,
                                       input logic r, input logic p, input logic u,
                                       input logic d, input logic l);
        return {t, o, r, p, u, d, l};
    endfunction

    // Drive inputs for one clock cycle and land 1 time unit after the edge
    // that registers their effect.
    task automatic applyStimulus(input logic hz, input logic st, input logic pt);
        clk_1hz   = hz;
        start     = st;
        pause_tgl = pt;
        @(posedge clk);
        #1;
        start     = 1'b0;
        pause_tgl = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [12:0] exp);
        logic [12:0] act;
        act = {sec_tens[sel], sec_ones[sel], running[sel], paused[sel],
               time_up[sel], done_pulse[sel], low_time[sel]};
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (dut%0d): got digits %0d%0d run=%b pau=%b up=%b pulse=%b low=%b, want digits %0d%0d run=%b pau=%b up=%b pulse=%b low=%b",
                     name, sel, act[12:9], act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[12:9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        // 3/2 round: full countdown, DONE behaviour and restart from DONE.
        addVec("d3_start",          1, 0,1,0, 0,3, 1,0,0,0,0);
        addVec("d3_tick_to_02",     1, 1,0,0, 0,2, 1,0,0,0,1);
        addVec("d3_hz_held_high",   1, 1,0,0, 0,2, 1,0,0,0,1);
        addVec("d3_hz_low",         1, 0,0,0, 0,2, 1,0,0,0,1);
        addVec("d3_tick_to_01",     1, 1,0,0, 0,1, 1,0,0,0,1);
        addVec("d3_hz_low_b",       1, 0,0,0, 0,1, 1,0,0,0,1);
        addVec("d3_tick_to_done",   1, 1,0,0, 0,0, 0,0,1,1,0);
        addVec("d3_pulse_one_cyc",  1, 0,0,0, 0,0, 0,0,1,0,0);
        addVec("d3_tick_in_done",   1, 1,0,0, 0,0, 0,0,1,0,0);
        addVec("d3_hz_low_done",    1, 0,0,0, 0,0, 0,0,1,0,0);
        addVec("d3_pause_in_done",  1, 0,0,1, 0,0, 0,0,1,0,0);
        addVec("d3_restart_done",   1, 0,1,0, 0,3, 1,0,0,0,0);
        // 12/10 round, entered here in RUN at 12 with clk_1hz low.
        addVec("d12_tick_11",       2, 1,0,0, 1,1, 1,0,0,0,0);
        addVec("d12_low_a",         2, 0,0,0, 1,1, 1,0,0,0,0);
        addVec("d12_tick_10",       2, 1,0,0, 1,0, 1,0,0,0,1);
        addVec("d12_low_b",         2, 0,0,0, 1,0, 1,0,0,0,1);
        addVec("d12_10_to_09",      2, 1,0,0, 0,9, 1,0,0,0,1);
        addVec("d12_low_c",         2, 0,0,0, 0,9, 1,0,0,0,1);
        addVec("d12_tick_08",       2, 1,0,0, 0,8, 1,0,0,0,1);
        addVec("d12_low_d",         2, 0,0,0, 0,8, 1,0,0,0,1);
        addVec("d12_tick_07",       2, 1,0,0, 0,7, 1,0,0,0,1);
        addVec("d12_low_e",         2, 0,0,0, 0,7, 1,0,0,0,1);
        addVec("d12_start_wins",    2, 1,1,1, 1,2, 1,0,0,0,0);
        addVec("d12_low_f",         2, 0,0,0, 1,2, 1,0,0,0,0);
        addVec("d12_t11",           2, 1,0,0, 1,1, 1,0,0,0,0);
        addVec("d12_l11",           2, 0,0,0, 1,1, 1,0,0,0,0);
        addVec("d12_t10",           2, 1,0,0, 1,0, 1,0,0,0,1);
        addVec("d12_l10",           2, 0,0,0, 1,0, 1,0,0,0,1);
        addVec("d12_t09",           2, 1,0,0, 0,9, 1,0,0,0,1);
        addVec("d12_l09",           2, 0,0,0, 0,9, 1,0,0,0,1);
        addVec("d12_t08",           2, 1,0,0, 0,8, 1,0,0,0,1);
        addVec("d12_l08",           2, 0,0,0, 0,8, 1,0,0,0,1);
        addVec("d12_t07",           2, 1,0,0, 0,7, 1,0,0,0,1);
        addVec("d12_l07",           2, 0,0,0, 0,7, 1,0,0,0,1);
        addVec("d12_t06",           2, 1,0,0, 0,6, 1,0,0,0,1);
        addVec("d12_l06",           2, 0,0,0, 0,6, 1,0,0,0,1);
        addVec("d12_t05",           2, 1,0,0, 0,5, 1,0,0,0,1);
        addVec("d12_l05",           2, 0,0,0, 0,5, 1,0,0,0,1);
        addVec("d12_pause_on_tick", 2, 1,0,1, 0,5, 0,1,0,0,1);
        addVec("d12_paused_low",    2, 0,0,0, 0,5, 0,1,0,0,1);
        addVec("d12_paused_edge1",  2, 1,0,0, 0,5, 0,1,0,0,1);
        addVec("d12_paused_low2",   2, 0,0,0, 0,5, 0,1,0,0,1);
        addVec("d12_paused_edge2",  2, 1,0,0, 0,5, 0,1,0,0,1);
        addVec("d12_paused_low3",   2, 0,0,0, 0,5, 0,1,0,0,1);
        addVec("d12_resume",        2, 0,0,1, 0,5, 1,0,0,0,1);
        addVec("d12_resume_tick",   2, 1,0,0, 0,4, 1,0,0,0,1);
        addVec("d12_at_04",         2, 0,0,0, 0,4, 1,0,0,0,1);

        // Reset while clk_1hz keeps toggling: everything stays at reset values.
        rst_n = 1'b0; clk_1hz = 1'b0; start = 1'b0; pause_tgl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clk_1hz = ~clk_1hz;
            @(posedge clk);
            #1;
        end
        checkOutput("reset_state_60", 0, pk(6,0,0,0,0,0,0));
        checkOutput("reset_state_3",  1, pk(0,3,0,0,0,0,0));
        checkOutput("reset_state_12", 2, pk(1,2,0,0,0,0,0));

        // Release with clk_1hz already high: the resulting tick hits IDLE.
        clk_1hz = 1'b1;
        rst_n   = 1'b1;
        applyStimulus(1, 0, 0);
        checkOutput("idle_first_tick", 0, pk(6,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0);
            applyStimulus(1, 0, 0);
        end
        applyStimulus(0, 0, 0);
        checkOutput("idle_three_edges", 0, pk(6,0,0,0,0,0,0));
        applyStimulus(0, 0, 1);
        checkOutput("idle_pause_ignored", 0, pk(6,0,0,0,0,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].hz, vecs[i].st, vecs[i].pt);
            checkOutput(vecs[i].name, vecs[i].sel,
                        pk(vecs[i].tens, vecs[i].ones, vecs[i].run, vecs[i].pau,
                           vecs[i].tu, vecs[i].dp, vecs[i].low));
        end

        // Asynchronous reset mid-RUN at 04 takes effect before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_now", 2, pk(1,2,0,0,0,0,0));
        applyStimulus(1, 0, 0);
        checkOutput("reset_held_tick", 2, pk(1,2,0,0,0,0,0));
        applyStimulus(0, 0, 0);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        checkOutput("after_reset_idle", 2, pk(1,2,0,0,0,0,0));

        // 60/10 round: tens borrow at 60->59 and 20->19.
        applyStimulus(0, 1, 0);
        checkOutput("d60_start", 0, pk(6,0,1,0,0,0,0));
        applyStimulus(1, 0, 0);
        checkOutput("d60_60_to_59", 0, pk(5,9,1,0,0,0,0));
        for (int i = 0; i < 39; i++) begin
            applyStimulus(0, 0, 0);
            applyStimulus(1, 0, 0);
        end
        applyStimulus(0, 0, 0);
        checkOutput("d60_at_20", 0, pk(2,0,1,0,0,0,0));
        applyStimulus(1, 0, 0);
        checkOutput("d60_20_to_19", 0, pk(1,9,1,0,0,0,0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
